mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- CPU-side initiator for the LC-3b memory handshake (ldMar / ldMdr / rw / datasize / R).
- Takes one load or store request from the datapath, sequences MAR and MDR loads onto the memory bus, and waits for R.
- Returns load data to the datapath: sign-extended for byte accesses, raw for words.
- Sits between the control/datapath and the memory block; it is the only driver of the memory-side strobes.

Parameters:
- ADDR_W, 16, address and bus width.
- TIMEOUT_CYCLES, 32, maximum cycles spent waiting for mem_r before aborting.

Ports:
- clk_50  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  datapath request strobe.
- req_ready  out  1  high when the controller is in IDLE; a request is accepted when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = 8-bit access, 0 = 16-bit access.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  16  store data; bits [7:0] are used for byte stores.
- resp_valid  out  1  one-cycle pulse when the access completes.
- resp_rdata  out  16  load result; 0 for stores.
- resp_err  out  1  qualified by resp_valid; set on timeout or unaligned trap.
- mem_ldMar  out  1  one-cycle MAR load strobe.
- mem_ldMdr  out  1  one-cycle MDR load strobe.
- mem_rw  out  1  1 = write; held from the DATA state through WAIT.
- mem_datasize  out  1  1 = byte, 0 = word; held for the whole access.
- mem_bus  out  ADDR_W  address during ADDR, write data during DATA, 0 otherwise.
- mem_r  in  1  memory ready.
- mem_rdata  in  16  memory read word, sampled when mem_r is high.

Behaviour:
- Reset values: all outputs 0 except req_ready = 1. State = IDLE, timeout counter = 0. Reset is honoured in any state, including mid-access; mem strobes drop immediately and no resp_valid is issued.
- FSM states and transitions:
  - IDLE: on accept, latch write, byte, addr and wdata; go to ADDR.
  - ADDR: mem_ldMar = 1, mem_bus = addr. Next state is DATA for stores, WAIT for loads.
  - DATA: mem_ldMdr = 1, mem_rw = 1. mem_bus = wdata for words, {wdata[7:0], wdata[7:0]} for bytes. Go to WAIT.
  - WAIT: the counter increments each cycle.
    - If mem_r: capture the result and go to DONE.
    - Else if counter == TIMEOUT_CYCLES-1: set err and go to DONE.
  - DONE: resp_valid = 1 for exactly one cycle, then go to IDLE.
- Load result:
  - Word: resp_rdata = mem_rdata.
  - Byte, addr[0] = 0: sign-extend mem_rdata[15:8].
  - Byte, addr[0] = 1: sign-extend mem_rdata[7:0].
  - Store: resp_rdata = 0.
- Latency, accept to resp_valid with mem_r arriving N cycles into WAIT (N ≥ 0):
  - Load: 3+N cycles.
  - Store: 4+N cycles.
- On timeout, resp_rdata = 0 and resp_err = 1.
- mem_r is ignored outside WAIT.
- req_valid is ignored when not in IDLE; there is no queueing.
- A new request is accepted in the cycle after DONE (back-to-back supported).
- The counter clears on entry to ADDR and is 8 bits wide. TIMEOUT_CYCLES ≤ 255.

Optional Feature:
- Macro: UNALIGNED_TRAP_EN.
- Defined: a word request with addr[0] = 1 skips the memory access. The controller goes IDLE → DONE with resp_err = 1 and resp_rdata = 0, so resp_valid arrives 1 cycle after accept and no strobes are issued.
- Undefined: addr[0] is forced to 0 for word accesses, and the access proceeds normally.

Decomposition:
- Shared package lc3b_mem_pkg holds:
  - the state enum (IDLE, ADDR, DATA, WAIT, DONE);
  - the DATASIZE_BYTE/DATASIZE_WORD constants;
  - the RW_READ/RW_WRITE constants.
- One sub-module, byte_lane_sext: selects a byte by addr[0] and sign-extends it to 16 bits. It is combinational and shared with the load path.

Test Plan:
- Word load at 0x0040, memory model returns 0x1234 with mem_r 2 cycles into WAIT → one ldMar pulse with bus = 0x0040, no ldMdr, resp_valid at accept+5, resp_rdata = 0x1234, resp_err = 0.
- Byte load at 0x0041, mem_rdata = 0x12F0 → resp_rdata = 0xFFF0. Repeat at 0x0040 → 0x0012.
- Word store of 0x0007 to 0x0000 → ldMar with bus = 0x0000, next cycle ldMdr with bus = 0x0007 and rw = 1, datasize = 0; resp_valid with resp_err = 0 after mem_r.
- mem_r never asserted (TIMEOUT_CYCLES = 32) → resp_valid 35 cycles after accept, resp_err = 1, resp_rdata = 0. The next request is accepted normally.
- Reset asserted mid-WAIT → outputs return to reset values asynchronously, and no resp_valid is issued. A subsequent byte store of 0x00AB at 0x0003 drives bus = 0xABAB with datasize = 1.
- With UNALIGNED_TRAP_EN defined, a word load at 0x0005 → no ldMar, resp_valid 1 cycle after accept, resp_err = 1.

Source files
------------

// File: rtl/lc3b_mem_pkg.sv
// Shared types and constants for the LC-3b memory access controller.
// Holds the controller state enum and the rw / datasize strobe encodings.
package lc3b_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WAIT,
        DONE
    } mem_state_t;

    localparam logic DATASIZE_BYTE = 1'b1;
    localparam logic DATASIZE_WORD = 1'b0;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/byte_lane_sext.sv
// Picks one byte lane of a 16-bit word and sign-extends it to 16 bits.
// Ports: word (16-bit input), sel_lo (1 = bits [7:0], 0 = bits [15:8]), sext (result).
module byte_lane_sext (
    input  logic [15:0] word,
    input  logic        sel_lo,
    output logic [15:0] sext
);

    logic [7:0] lane;

    assign lane = sel_lo ? word[7:0] : word[15:8];
    assign sext = {{8{lane[7]}}, lane};

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3b CPU-side memory initiator: one load/store per request, driving
// ldMar/ldMdr/rw/datasize/bus and waiting on mem_r with a timeout.
// Ports: clk_50, reset (async, active-high); req_* datapath request side;
// resp_* one-cycle completion with data/error; mem_* memory handshake.
// Build option: define UNALIGNED_TRAP_EN to trap odd-address word accesses
// instead of silently aligning them.
module mem_access_ctrl
    import lc3b_mem_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              resp_valid,
    output logic [15:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_ldMar,
    output logic              mem_ldMdr,
    output logic              mem_rw,
    output logic              mem_datasize,
    output logic [ADDR_W-1:0] mem_bus,
    input  logic              mem_r,
    input  logic [15:0]       mem_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_t  state;
    logic [7:0]  cnt;
    logic        lat_write;
    logic        lat_byte;
    logic        lat_addr_lo;
    logic [15:0] lat_wdata;

    logic              unaligned_trap;
    logic [ADDR_W-1:0] eff_addr;
    logic [15:0]       store_word;
    logic [15:0]       sext_word;
    logic [15:0]       load_word;

`ifdef UNALIGNED_TRAP_EN
    assign unaligned_trap = ~req_byte & req_addr[0];
    assign eff_addr       = req_addr;
`else
    // Word accesses are silently aligned down to the even byte.
    assign unaligned_trap = 1'b0;
    assign eff_addr       = {req_addr[ADDR_W-1:1], req_byte & req_addr[0]};
`endif

    // Byte stores replicate the low byte onto both lanes.
    assign store_word = lat_byte ? {lat_wdata[7:0], lat_wdata[7:0]}
                                 : lat_wdata;

    byte_lane_sext u_sext (
        .word   (mem_rdata),
        .sel_lo (lat_addr_lo),
        .sext   (sext_word)
    );

    assign load_word = lat_byte ? sext_word : mem_rdata;

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            lat_write    <= 1'b0;
            lat_byte     <= 1'b0;
            lat_addr_lo  <= 1'b0;
            lat_wdata    <= '0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            mem_ldMar    <= 1'b0;
            mem_ldMdr    <= 1'b0;
            mem_rw       <= RW_READ;
            mem_datasize <= DATASIZE_WORD;
            mem_bus      <= '0;
        end else begin
            mem_ldMar  <= 1'b0;
            mem_ldMdr  <= 1'b0;
            resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write   <= req_write;
                        lat_byte    <= req_byte;
                        lat_addr_lo <= eff_addr[0];
                        lat_wdata   <= req_wdata;
                        req_ready   <= 1'b0;
                        if (unaligned_trap) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state        <= ADDR;
                            cnt          <= '0;
                            mem_ldMar    <= 1'b1;
                            mem_bus      <= eff_addr;
                            mem_datasize <= req_byte ? DATASIZE_BYTE
                                                     : DATASIZE_WORD;
                        end
                    end
                end
                ADDR: begin
                    if (lat_write) begin
                        state     <= DATA;
                        mem_ldMdr <= 1'b1;
                        mem_rw    <= RW_WRITE;
                        mem_bus   <= ADDR_W'(store_word);
                    end else begin
                        state   <= WAIT;
                        mem_bus <= '0;
                    end
                end
                DATA: begin
                    state   <= WAIT;
                    mem_bus <= '0;
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (mem_r) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= lat_write ? 16'h0000 : load_word;
                        mem_rw     <= RW_READ;
                    end else if (cnt == TO_LAST) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        mem_rw     <= RW_READ;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    req_ready    <= 1'b1;
                    resp_err     <= 1'b0;
                    resp_rdata   <= '0;
                    mem_datasize <= DATASIZE_WORD;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: driver pushes expected bus strobes
// and responses, a negedge monitor pops and compares them.
module tb_mem_access_ctrl;

    localparam int TO = 32;

    logic        clk_50 = 1'b0;
    logic        reset  = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        mem_ldMar;
    logic        mem_ldMdr;
    logic        mem_rw;
    logic        mem_datasize;
    logic [15:0] mem_bus;
    logic        mem_r = 1'b0;
    logic [15:0] mem_rdata = '0;

    mem_access_ctrl #(.ADDR_W(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk_50       (clk_50),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_byte     (req_byte),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_ldMar    (mem_ldMar),
        .mem_ldMdr    (mem_ldMdr),
        .mem_rw       (mem_rw),
        .mem_datasize (mem_datasize),
        .mem_bus      (mem_bus),
        .mem_r        (mem_r),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk_50 = ~clk_50;

    int cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        int          cyc;
        logic        mdr;
        logic [15:0] bus;
        logic        rw;
        logic        ds;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"},
            {26'd0, req_ready, resp_valid, mem_ldMar, mem_ldMdr,
             mem_rw, mem_datasize}, 32'b100000);
        chk({tag, "_bus"}, {16'd0, mem_bus}, 32'd0);
        chk({tag, "_resp"}, {15'd0, resp_err, resp_rdata}, 32'd0);
    endtask

    // Reference load result from the addressing rules, using int arithmetic.
    function automatic logic [15:0] exp_load(input logic bt,
                                             input logic [15:0] a,
                                             input logic [15:0] w);
        int b;
        if (!bt) return w;
        b = a[0] ? int'(w[7:0]) : int'(w[15:8]);
        if (b > 127) b = b - 256;
        return 16'(b);
    endfunction

    // Monitor
    always @(negedge clk_50) begin
        resp_t r;
        bus_t  e;
        if (!reset) begin
            if (resp_valid) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_resp: got resp_valid expected none (cycle %0d)", cyc);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_cycle", cyc, r.cyc);
                    chk("resp_rdata", {16'd0, resp_rdata}, {16'd0, r.rdata});
                    chk("resp_err", {31'd0, resp_err}, {31'd0, r.err});
                end
            end
            if (mem_ldMar || mem_ldMdr) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_strobe: got mar=%0b mdr=%0b expected none (cycle %0d)",
                             mem_ldMar, mem_ldMdr, cyc);
                end else begin
                    e = bus_q.pop_front();
                    chk("strobe_kind", {30'd0, mem_ldMar, mem_ldMdr},
                        {30'd0, ~e.mdr, e.mdr});
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("strobe_bus", {16'd0, mem_bus}, {16'd0, e.bus});
                    chk("strobe_rw", {31'd0, mem_rw}, {31'd0, e.rw});
                    chk("strobe_ds", {31'd0, mem_datasize}, {31'd0, e.ds});
                end
            end
        end
    end

    // Issue one request; n = WAIT cycles before mem_r, abort_at = cycle
    // offset at which reset is forced (0 = never).
    task automatic do_req(input logic wr, input logic bt,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] mword, input int n,
                          input int abort_at);
        int    c0, ws, len, g;
        logic  trap, err;
        logic [15:0] ea, rd, lanes;
        resp_t r;
        bus_t  b;

        @(negedge clk_50);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        g = 0;
        while (!req_ready && g < 100) begin
            @(negedge clk_50);
            g++;
        end
        if (!req_ready) return;

        trap = 1'b0;
`ifdef UNALIGNED_TRAP_EN
        trap = !bt && addr[0];
`endif
        ea = (!bt && !trap) ? (addr & 16'hFFFE) : addr;
        ws = wr ? 3 : 2;
        if (trap) begin
            len = 1;
            err = 1'b1;
        end else if (n <= TO - 1) begin
            len = ws + n + 1;
            err = 1'b0;
        end else begin
            len = ws + TO;
            err = 1'b1;
        end
        rd = (err || wr) ? 16'h0000 : exp_load(bt, addr, mword);
        lanes = bt ? {wdata[7:0], wdata[7:0]} : wdata;

        c0 = cyc;
        req_valid = 1'b1;
        req_write = wr;
        req_byte  = bt;
        req_addr  = addr;
        req_wdata = wdata;
        mem_r     = 1'($urandom % 2);
        mem_rdata = 16'($urandom);

        r.cyc = c0 + len; r.rdata = rd; r.err = err;
        resp_q.push_back(r);
        if (!trap) begin
            b.cyc = c0 + 1; b.mdr = 1'b0; b.bus = ea; b.rw = 1'b0; b.ds = bt;
            bus_q.push_back(b);
            if (wr) begin
                b.cyc = c0 + 2; b.mdr = 1'b1; b.bus = lanes;
                b.rw = 1'b1; b.ds = bt;
                bus_q.push_back(b);
            end
        end

        for (int t = 1; t <= len; t++) begin
            @(negedge clk_50);
            if (abort_at == t) begin
                #2 reset = 1'b1;
                req_valid = 1'b0;
                mem_r = 1'b0;
                #1 chk_reset("abort");
                void'(resp_q.pop_back());
                @(negedge clk_50);
                @(negedge clk_50);
                reset = 1'b0;
                break;
            end
            // Junk on the request port while busy must be ignored.
            req_valid = (t < len) ? 1'($urandom % 2) : 1'b0;
            req_write = 1'($urandom % 2);
            req_addr  = 16'($urandom);
            if (trap || t < ws) begin
                mem_r     = 1'($urandom % 2);
                mem_rdata = 16'($urandom);
            end else if (t == ws + n) begin
                mem_r     = 1'b1;
                mem_rdata = mword;
            end else begin
                mem_r     = 1'b0;
                mem_rdata = 16'($urandom);
            end
        end
        mem_r = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n;
        repeat (3) @(negedge clk_50);
        chk_reset("por");
        reset = 1'b0;

        // Word load, mem_r two cycles into WAIT.
        do_req(1'b0, 1'b0, 16'h0040, 16'h0000, 16'h1234, 2, 0);
        // Byte loads, both lanes.
        do_req(1'b0, 1'b1, 16'h0041, 16'h0000, 16'h12F0, 0, 0);
        do_req(1'b0, 1'b1, 16'h0040, 16'h0000, 16'h12F0, 1, 0);
        // Word store.
        do_req(1'b1, 1'b0, 16'h0000, 16'h0007, 16'h0000, 1, 0);
        // Timeout on a store, then a normal back-to-back load.
        do_req(1'b1, 1'b0, 16'h0100, 16'h5555, 16'h0000, 300, 0);
        do_req(1'b0, 1'b0, 16'h0102, 16'h0000, 16'hBEEF, 0, 0);
        // mem_r on the very last allowed WAIT cycle.
        do_req(1'b0, 1'b0, 16'h0200, 16'h0000, 16'h8001, TO - 1, 0);
        // Reset mid-WAIT of a byte store, then a byte store.
        do_req(1'b1, 1'b1, 16'h0003, 16'h00AB, 16'h0000, 300, 5);
        do_req(1'b1, 1'b1, 16'h0003, 16'h00AB, 16'h0000, 0, 0);
        // Odd-address word load (trap or align depending on build).
        do_req(1'b0, 1'b0, 16'h0005, 16'h0000, 16'h7777, 1, 0);

        for (int i = 0; i < 40; i++) begin
            k = int'($urandom % 10);
            if (k < 7) n = int'($urandom % 5);
            else if (k == 7) n = TO - 1;
            else n = TO + int'($urandom % 4);
            do_req(1'($urandom % 2), 1'($urandom % 2), 16'($urandom),
                   16'($urandom), 16'($urandom), n, 0);
        end

        repeat (3) @(negedge clk_50);
        chk("resp_q_drained", resp_q.size(), 32'd0);
        chk("bus_q_drained", bus_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
